// File: rtl/tproc_pkg.sv
// Shared definitions for the tiny processor: opcode constants, fetch FSM
// state encoding and small arithmetic helpers used by fetch and decode.
package tproc_pkg;

  // Opcode field lives in the top byte of every 64-bit instruction word.
  localparam logic [7:0] OPC_NULL = 8'h82;  // terminates the program run
  localparam logic [7:0] OPC_HOLD = 8'h44;  // parks fetch until resume

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_STALL     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_DONE      = 3'd6
  } fetch_state_t;

  // Extract the opcode byte from an instruction word.
  function automatic logic [7:0] opcode_of(input logic [63:0] word);
    return word[63:56];
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks instruction RAM from a base address,
// hands each word to the decoder with a one-cycle qualifier, and reacts to
// end-of-program / hold opcodes, downstream back-pressure and a run limit.
//
// RAM interface: fixed-latency read, no ready. mem_rd_en is a one-cycle
// request with mem_addr; mem_rdata is valid exactly one cycle later and is
// captured unconditionally in WAIT_DATA. The decoder side is push-only:
// instruction is valid only in the cycle instr_enable is high; exe_busy is
// the sole back-pressure and is sampled at ISSUE exit and in STALL.
module instr_fetch_ctrl
  import tproc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  base_addr,
  input  logic [15:0]  instr_count,
  input  logic         exe_busy,
  input  logic         resume,
  output logic         mem_rd_en,
  output logic [15:0]  mem_addr,
  input  logic [63:0]  mem_rdata,
  output logic [63:0]  instruction,
  output logic         instr_enable,
  output logic         busy,
  output logic         hold,
  output logic         done,
  output logic [15:0]  issued_count,
  output fetch_state_t state_dbg
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [15:0]  pc;
  logic [15:0]  count_lim;
  logic [15:0]  issued_inc;
  logic [7:0]   opcode;

  assign issued_inc = sat_inc16(issued_count);
  assign opcode     = opcode_of(instruction);
  assign state_dbg  = state;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ISSUE exit follows opcode, then run limit, then back-pressure.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (instr_count == 16'd0) ? ST_DONE : ST_READ;
      end
      ST_READ:      state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (opcode == OPC_NULL)            state_nxt = ST_DONE;
        else if (opcode == OPC_HOLD)       state_nxt = ST_HOLD;
        else if (issued_inc == count_lim)  state_nxt = ST_DONE;
        else if (exe_busy)                 state_nxt = ST_STALL;
        else                               state_nxt = ST_READ;
      end
      ST_STALL: begin
        if (!exe_busy) state_nxt = ST_READ;
      end
      ST_HOLD: begin
        if (resume) state_nxt = exe_busy ? ST_STALL : ST_READ;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: run parameters on start, data capture, issue counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= 16'h0;
      count_lim    <= 16'h0;
      issued_count <= 16'h0;
      instruction  <= 64'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc           <= base_addr;
            count_lim    <= instr_count;
            issued_count <= 16'h0;
          end
        end
        ST_WAIT_DATA: begin
          instruction <= mem_rdata;
          pc          <= pc + 16'd1;
        end
        ST_ISSUE: issued_count <= issued_inc;
        default: ;
      endcase
    end
  end

  // Strobes decoded from state so none can assert outside its own state.
  always_comb begin
    mem_rd_en    = (state == ST_READ);
    mem_addr     = (state == ST_READ) ? pc : 16'h0;
    instr_enable = (state == ST_ISSUE);
    busy         = (state != ST_IDLE);
    hold         = (state == ST_HOLD);
    done         = (state == ST_DONE);
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a random
// phase, all checked every cycle against a run-level behavioural model.
module tb_instr_fetch_ctrl;
  import tproc_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  base_addr = 16'h0;
  logic [15:0]  instr_count = 16'h0;
  logic         exe_busy = 1'b0;
  logic         resume = 1'b0;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [63:0]  mem_rdata = 64'h0;
  logic [63:0]  instruction;
  logic         instr_enable;
  logic         busy;
  logic         hold;
  logic         done;
  logic [15:0]  issued_count;
  fetch_state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] ram [0:65535];

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .instr_count(instr_count), .exe_busy(exe_busy), .resume(resume),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instruction(instruction), .instr_enable(instr_enable), .busy(busy),
    .hold(hold), .done(done), .issued_count(issued_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // RAM: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    else           mem_rdata <= {$urandom(), $urandom()};
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Tracks a run as scheduled events (cycle of next read, issue, done) and
  // the instruction words expected in order.
  logic [63:0] exp_q[$];
  bit          armed = 1'b0;
  int          cyc = 0;
  int          m_read_at = -1;
  int          m_issue_at = -1;
  int          m_done_at = -1;
  bit          m_active = 1'b0;
  bit          m_wait_busy = 1'b0;
  bit          m_holding = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_lim = 16'h0;
  logic [15:0] m_issued = 16'h0;
  logic [63:0] m_instr = 64'h0;
  bit          e_rd, e_iss, e_done, e_busy, e_hold;
  logic [7:0]  m_op;

  always @(negedge clk) begin
    cyc++;
    e_rd   = (cyc == m_read_at);
    e_iss  = (cyc == m_issue_at);
    e_done = (cyc == m_done_at);
    e_busy = m_active;
    e_hold = m_holding;
    if (e_iss) m_instr = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;

    if (armed) begin
      check_eq("mem_rd_en", 64'(mem_rd_en), 64'(e_rd));
      if (e_rd) check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
      check_eq("instr_enable", 64'(instr_enable), 64'(e_iss));
      check_eq("instruction", instruction, m_instr);
      check_eq("busy", 64'(busy), 64'(e_busy));
      check_eq("hold", 64'(hold), 64'(e_hold));
      check_eq("done", 64'(done), 64'(e_done));
      check_eq("issued_count", 64'(issued_count), 64'(m_issued));
    end

    if (rst) begin
      exp_q.delete();
      m_read_at = -1; m_issue_at = -1; m_done_at = -1;
      m_active = 0; m_wait_busy = 0; m_holding = 0;
      m_addr = 16'h0; m_lim = 16'h0; m_issued = 16'h0; m_instr = 64'h0;
    end else begin
      if (e_done) m_active = 0;
      if (!e_busy && start) begin
        m_active = 1;
        m_lim    = instr_count;
        m_issued = 16'h0;
        m_addr   = base_addr;
        if (instr_count == 16'h0) m_done_at = cyc + 1;
        else                      m_read_at = cyc + 1;
      end
      if (e_rd) begin
        exp_q.push_back(ram[m_addr]);
        m_issue_at = cyc + 2;
        m_addr     = m_addr + 16'd1;
      end
      if (e_iss) begin
        m_op     = m_instr[63:56];
        m_issued = (m_issued == 16'hFFFF) ? m_issued : m_issued + 16'd1;
        if (m_op == 8'h82)            m_done_at = cyc + 1;
        else if (m_op == 8'h44)       m_holding = 1;
        else if (m_issued == m_lim)   m_done_at = cyc + 1;
        else if (exe_busy)            m_wait_busy = 1;
        else                          m_read_at = cyc + 1;
      end else if (m_wait_busy && !exe_busy) begin
        m_wait_busy = 0;
        m_read_at   = cyc + 1;
      end else if (m_holding && resume) begin
        m_holding = 0;
        if (exe_busy) m_wait_busy = 1;
        else          m_read_at = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ordinary_word();
    logic [7:0] op;
    op = 8'($urandom_range(0, 255));
    if (op == 8'h82 || op == 8'h44) op = 8'h01;
    return {op, 24'($urandom()), 32'($urandom())};
  endfunction

  task automatic fill_ram(input bit specials);
    int r;
    for (int a = 0; a < 65536; a++) begin
      ram[a] = ordinary_word();
      if (specials) begin
        r = $urandom_range(0, 19);
        if (r == 0) ram[a][63:56] = 8'h82;
        if (r == 1) ram[a][63:56] = 8'h44;
      end
    end
  endtask

  task automatic launch(input logic [15:0] base, input logic [15:0] cnt);
    start = 1'b1; base_addr = base; instr_count = cnt;
    step();
    start = 1'b0;
  endtask

  // Waits for the run to finish, releasing holds so it always ends.
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      resume = hold;
      step();
      n++;
    end
    resume = 1'b0;
    check_eq("run_ends", 64'(busy), 64'd0);
  endtask

  task automatic wait_for_issue(input int budget);
    int n = 0;
    while (!instr_enable && n < budget) begin step(); n++; end
    check_eq("issue_seen", 64'(instr_enable), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    fill_ram(1'b0);
    rst = 1'b1;
    step(); step();
    armed = 1'b1;
    step();
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst = 1'b0;
    step();

    // Plain three-instruction run.
    launch(16'h0010, 16'd3);
    wait_idle(100);
    check_eq("run3_count", 64'(issued_count), 64'd3);
    step();

    // End-of-program opcode cuts a longer run short.
    ram[16'h0002][63:56] = 8'h82;
    launch(16'h0000, 16'd8);
    wait_idle(100);
    check_eq("null_count", 64'(issued_count), 64'd3);
    step();

    // Hold opcode parks fetch until resume.
    ram[16'h0031][63:56] = 8'h44;
    launch(16'h0030, 16'd4);
    n = 0;
    while (!hold && n < 50) begin step(); n++; end
    check_eq("hold_seen", 64'(hold), 64'd1);
    repeat (4) step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    check_eq("resume_read", 64'(mem_rd_en), 64'd1);
    check_eq("resume_addr", 64'(mem_addr), 64'h0032);
    wait_idle(100);
    step();

    // Back-pressure right after the first issue.
    launch(16'h0100, 16'd3);
    wait_for_issue(20);
    exe_busy = 1'b1;
    repeat (5) step();
    exe_busy = 1'b0;
    wait_idle(100);
    step();

    // Address wrap and zero-length run.
    launch(16'hFFFF, 16'd2);
    wait_idle(100);
    launch(16'h1234, 16'd0);
    wait_idle(10);
    step();

    // Reset while waiting for RAM data, then a restart ignored mid-run.
    launch(16'h0200, 16'd4);
    n = 0;
    while (!mem_rd_en && n < 20) begin step(); n++; end
    check_eq("pre_rst_read", 64'(mem_rd_en), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    step();
    launch(16'h0300, 16'd3);
    step();
    launch(16'h0400, 16'd6);
    wait_idle(100);
    check_eq("restart_ignored_count", 64'(issued_count), 64'd3);
    step();

    // Random phase: random RAM with special opcodes, random controls.
    rst = 1'b1;
    fill_ram(1'b1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 249) == 0);
      start       = ($urandom_range(0, 5) == 0);
      base_addr   = 16'($urandom());
      instr_count = 16'($urandom_range(0, 7));
      exe_busy    = ($urandom_range(0, 2) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; exe_busy = 1'b0; resume = 1'b0;
    wait_idle(200);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 clk  input  1  clock; all logic rising-edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle pulse; launches a program run (sampled in IDLE only).
REQ-004 base_addr  input  16  first instruction word address, latched on accepted start.
REQ-005 instr_count  input  16  max instructions to issue, latched on accepted start.
REQ-006 exe_busy  input  1  downstream execution busy; blocks next fetch while high.
REQ-007 resume  input  1  one-cycle pulse; releases HOLD.
REQ-008 mem_rd_en  output  1  instruction RAM read strobe.
REQ-009 mem_addr  output  16  instruction RAM word address.
REQ-010 mem_rdata  input  64  RAM data, valid exactly one cycle after mem_rd_en.
REQ-011 instruction  output  64  instruction word to decoder.
REQ-012 instr_enable  output  1  one-cycle qualifier for instruction.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 hold  output  1  high while in HOLD.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 issued_count  output  16  instructions issued in current run.

Function
REQ-017 States SHALL be IDLE, READ, WAIT_DATA, ISSUE, STALL, HOLD, DONE.
REQ-018 IDLE: start=1 SHALL latch base_addr into pc, latch instr_count, clear issued_count, go to READ; if instr_count=0, go to DONE instead.
REQ-019 READ: mem_rd_en=1, mem_addr=pc for exactly one cycle, then WAIT_DATA.
REQ-020 WAIT_DATA: instruction SHALL register mem_rdata, pc SHALL increment (wrap 0xFFFF->0x0000), go to ISSUE.
REQ-021 ISSUE: instr_enable=1 for exactly one cycle; issued_count increments by 1 (saturates at 0xFFFF).
REQ-022 Latency: mem_rd_en at cycle T -> instr_enable at T+2; minimum issue interval 3 cycles.
REQ-023 ISSUE exit priority: opcode instruction[63:56]=8'h82 -> DONE; else opcode=8'h44 -> HOLD; else issued_count (post-increment) = latched count -> DONE; else exe_busy=1 -> STALL; else READ.
REQ-024 STALL: remain while exe_busy=1; go to READ on first cycle exe_busy=0.
REQ-025 HOLD: hold=1; resume=1 with exe_busy=0 -> READ; resume=1 with exe_busy=1 -> STALL; resume outside HOLD ignored.
REQ-026 DONE: done=1 for one cycle, then IDLE; instruction retains last value.
REQ-027 start while busy=1 SHALL be ignored and SHALL not alter latched parameters.
REQ-028 instr_enable SHALL never assert outside ISSUE; mem_rd_en SHALL never assert outside READ.

Reset
REQ-029 rst SHALL force IDLE and zero all outputs (instruction=64'h0, mem_addr=0, issued_count=0, all 1-bit outputs 0), pc and latched count to 0, in any state including mid-run.
REQ-030 rst has priority over start, resume and exe_busy in the same cycle; an in-flight RAM read is discarded.

Structure
REQ-031 Opcode constants OPC_NULL=8'h82 and OPC_HOLD=8'h44 and the state encoding SHALL live in the shared package tproc_pkg, also used by instruction_decode.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 base_addr=0x0010, instr_count=3, RAM ordinary opcodes, exe_busy=0 -> reads at 0x10/0x11/0x12, instr_enable pulses 3 cycles apart, done one cycle after third ISSUE, issued_count=3.
REQ-034 count=8, word at 0x0002 has opcode 0x82, base=0 -> exactly 3 issues, done, no read of address 0x0003.
REQ-035 word 1 opcode 0x44 -> hold=1 after its issue, no mem_rd_en until resume; resume pulse -> read of next address next cycle.
REQ-036 exe_busy held high 5 cycles after first issue -> no mem_rd_en during those cycles; read on first cycle exe_busy=0.
REQ-037 base=0xFFFF, count=2 -> reads 0xFFFF then 0x0000; start with count=0 -> done pulse, no read.
REQ-038 rst asserted in WAIT_DATA -> next cycle IDLE, all outputs 0, no instr_enable; start re-issued mid-run -> ignored.
